// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle MU0 ALU: op codes, FSM states and flag layout.
package alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_INC  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
    localparam logic [OP_W-1:0] OP_CMP  = 3'b111;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Places individual flag bits at their fixed positions in the flags word
    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic zf,
                                                     input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f        = '0;
        f[FLG_N] = n;
        f[FLG_Z] = zf;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response channel between the MU0 control FSM (master) and the ALU (slave).
interface alu_mc_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  z;
    logic [FLAG_W-1:0] flags;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, z, flags
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, z, flags
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: operand bit 0 is consumed at start, then one bit per cycle.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             running;

    // cnt counts the remaining busy cycles; the product is complete when it reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CW'(WIDTH - 1);
            acc     <= y[0] ? PW'(x) : '0;
            mcand   <= PW'(x) << 1;
            mplier  <= y >> 1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt    <= cnt - CW'(1);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
            end
        end
    end

    assign done = running && (cnt == '0);
    assign prod = acc;

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU for the MU0 datapath with valid/ready request and response channels.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    state_t            state;
    logic [WIDTH-1:0]  z_q;
    logic [FLAG_W-1:0] flags_q;
    logic              out_valid_q;

    logic              in_ready_c;
    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic [PW-1:0]     mul_prod;
    logic [FLAG_W-1:0] mul_flags;

    logic [WIDTH-1:0]  b_opnd;
    logic              cin;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  res;
    logic              res_c;
    logic              res_v;
    logic [WIDTH-1:0]  sc_z;
    logic [FLAG_W-1:0] sc_flags;

    assign in_ready_c = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign is_mul     = MUL_EN && (bus.op == OP_MUL);

    // Single-cycle ops share one adder; SUB/CMP use x + ~y + 1
    always_comb begin
        b_opnd = bus.y;
        cin    = 1'b0;
        case (bus.op)
            OP_INC:         begin b_opnd = '0;     cin = 1'b1; end
            OP_SUB, OP_CMP: begin b_opnd = ~bus.y; cin = 1'b1; end
            default: ;
        endcase
        sum   = {1'b0, bus.x} + {1'b0, b_opnd} + W1'(cin);
        res   = bus.y;
        res_c = 1'b0;
        res_v = 1'b0;
        case (bus.op)
            OP_ADD, OP_INC, OP_SUB, OP_CMP: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (bus.x[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_AND:  res = bus.x & bus.y;
            OP_OR:   res = bus.x | bus.y;
            default: res = bus.y;
        endcase
        sc_flags = pack_flags(res[WIDTH-1], res == '0, res_c, res_v);
        sc_z     = (bus.op == OP_CMP) ? z_q : res;
    end

    generate
        if (MUL_EN) begin : g_mul
            logic mul_start;
            assign mul_start = accept && is_mul;
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .start (mul_start),
                .x     (bus.x),
                .y     (bus.y),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    assign mul_flags = pack_flags(mul_prod[WIDTH-1], mul_prod[WIDTH-1:0] == '0,
                                  |mul_prod[PW-1:WIDTH], 1'b0);

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            z_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        out_valid_q <= !is_mul;
                        if (is_mul) begin
                            state <= ST_BUSY;
                        end else begin
                            state   <= ST_DONE;
                            z_q     <= sc_z;
                            flags_q <= sc_flags;
                        end
                    end else if ((state == ST_DONE) && bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state       <= ST_DONE;
                        z_q         <= mul_prod[WIDTH-1:0];
                        flags_q     <= mul_flags;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner cases and random ops vs a reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc_if #(.WIDTH(W)) bus2 ();

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_mc #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ez;
        logic [3:0]  ef;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {z, flags} from plain integer arithmetic
    function automatic logic [19:0] ref_model(input logic [2:0] op, input logic [15:0] x,
                                              input logic [15:0] y, input logic [15:0] prevz);
        int     ux, uy, sx, sy, r, s;
        longint p;
        logic [15:0] res;
        logic c, v;
        ux = int'(x);  uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        c = 1'b0; v = 1'b0; res = y;
        case (op)
            3'd1: begin r = ux + uy; res = r[15:0]; c = (r > 65535);
                        s = sx + sy; v = (s > 32767) || (s < -32768); end
            3'd2: begin r = ux + 1;  res = r[15:0]; c = (r > 65535);
                        s = sx + 1;  v = (s > 32767); end
            3'd3, 3'd7: begin r = ux - uy; res = r[15:0]; c = (ux >= uy);
                        s = sx - sy; v = (s > 32767) || (s < -32768); end
            3'd4: res = x & y;
            3'd5: res = x | y;
            3'd6: begin p = longint'(ux) * longint'(uy); res = p[15:0]; c = (p >= 65536); end
            default: res = y;
        endcase
        return {(op == 3'd7) ? prevz : res, res[15], res == 16'h0, c, v};
    endfunction

    // Issue one op from IDLE with out_ready high; report result, latency and not-ready cycles
    task automatic issue(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] rz, output logic [3:0] rf,
                         output int lat, output int nr, output bit ok);
        rz = '0; rf = '0; lat = 0; nr = 0; ok = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.x         = x;
        bus.y         = y;
        bus.out_ready = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.x        = 16'($urandom);
        bus.y        = 16'($urandom);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i; rz = bus.z; rf = bus.flags; ok = 1'b1;
                break;
            end
            if (!bus.in_ready) nr++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rz;
        logic [3:0]  rf;
        logic [19:0] m;
        logic [15:0] prevz;
        logic [15:0] tp_exp[4];
        int lat, nr, stale;
        bit ok;

        vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1};
        vecs[1]  = '{OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 4'b1000, 1};
        vecs[2]  = '{OP_CMP,  16'h0007, 16'h0007, 16'hFFFE, 4'b0110, 1};
        vecs[3]  = '{OP_INC,  16'hFFFF, 16'h1234, 16'h0000, 4'b0110, 1};
        vecs[4]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1};
        vecs[5]  = '{OP_OR,   16'h0000, 16'h0000, 16'h0000, 4'b0100, 1};
        vecs[6]  = '{OP_PASS, 16'h5555, 16'hABCD, 16'hABCD, 4'b1000, 1};
        vecs[7]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1};
        vecs[8]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1};
        vecs[9]  = '{OP_MUL,  16'h0100, 16'h0101, 16'h0100, 4'b0010, 17};
        vecs[10] = '{OP_MUL,  16'h00FF, 16'h0003, 16'h02FD, 4'b0000, 17};
        vecs[11] = '{OP_CMP,  16'h0003, 16'h0009, 16'h02FD, 4'b1000, 1};
        vecs[12] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17};
        vecs[13] = '{OP_OR,   16'h8000, 16'h0001, 16'h8001, 4'b1000, 1};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.op = '0; bus2.x = '0; bus2.y = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_z",         32'(bus.z),         32'h0);
        check("rst_flags",     32'(bus.flags),     32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);

        // MUL_EN=0: op 110 behaves as PASS_Y with one-cycle latency
        bus2.in_valid = 1'b1; bus2.op = OP_MUL; bus2.x = 16'h0003; bus2.y = 16'h8001;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("nomul_valid", 32'(bus2.out_valid), 32'h1);
        check("nomul_z",     32'(bus2.z),         32'h8001);
        check("nomul_flags", 32'(bus2.flags),     32'h8);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y, rz, rf, lat, nr, ok);
            check($sformatf("vec%0d_done", i),  32'(ok), 32'h1);
            check($sformatf("vec%0d_z", i),     32'(rz), 32'(vecs[i].ez));
            check($sformatf("vec%0d_flags", i), 32'(rf), 32'(vecs[i].ef));
            check($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i),  32'(nr), (vecs[i].lat > 1) ? 32'd16 : 32'd0);
        end

        // Backpressure: result held while out_ready is low
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = OP_INC; bus.x = 16'hFFFF; bus.y = 16'h0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",    32'(bus.out_valid), 32'h1);
            check("bp_z",        32'(bus.z),         32'h0);
            check("bp_flags",    32'(bus.flags),     32'h6);
            check("bp_in_ready", 32'(bus.in_ready),  32'h0);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.op = OP_ADD; bus.x = 16'd2; bus.y = 16'd3;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(bus.out_valid), 32'h1);
        check("bp_next_z",     32'(bus.z),         32'h5);
        check("bp_next_flags", 32'(bus.flags),     32'h0);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops with out_ready held high
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("tp_valid", 32'(bus.out_valid), 32'h1);
                check("tp_z",     32'(bus.z),         32'(tp_exp[k-1]));
            end
            bus.in_valid = 1'b1; bus.op = OP_ADD;
            bus.x = 16'(k * 1000 + 7); bus.y = 16'(k * 3);
            tp_exp[k] = 16'(k * 1003 + 7);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("tp_last_z", 32'(bus.z), 32'(tp_exp[3]));
        @(posedge clk);
        #1;

        // Reset during the eighth BUSY cycle of a multiply
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.x = 16'h0123; bus.y = 16'h0456;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy_ready", 32'(bus.in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("arst_z",         32'(bus.z),         32'h0);
        check("arst_flags",     32'(bus.flags),     32'h0);
        check("arst_out_valid", 32'(bus.out_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) stale++;
        end
        check("no_stale_valid", 32'(stale), 32'h0);
        issue(OP_PASS, 16'h1111, 16'hABCD, rz, rf, lat, nr, ok);
        check("post_rst_ok",    32'(ok),  32'h1);
        check("post_rst_z",     32'(rz),  32'hABCD);
        check("post_rst_flags", 32'(rf),  32'h8);
        check("post_rst_lat",   32'(lat), 32'd1);
        prevz = 16'hABCD;

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  rop;
            logic [15:0] rx, ry;
            rop = 3'($urandom);
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            m   = ref_model(rop, rx, ry, prevz);
            issue(rop, rx, ry, rz, rf, lat, nr, ok);
            check($sformatf("rnd%0d_op%0d_done", n, rop),  32'(ok), 32'h1);
            check($sformatf("rnd%0d_op%0d_z", n, rop),     32'(rz), 32'(m[19:4]));
            check($sformatf("rnd%0d_op%0d_flags", n, rop), 32'(rf), 32'(m[3:0]));
            check($sformatf("rnd%0d_op%0d_lat", n, rop),   32'(lat), (rop == OP_MUL) ? 32'd17 : 32'd1);
            prevz = m[19:4];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
